// File: rtl/l2_request_arbiter.sv
// l2_request_arbiter
// Shares the single L2 request port between the instruction cache and the
// data cache. A grant is held until a full cache line of fulfilled beats
// has completed, or until the owner withdraws its request (abort). The two
// line transfers are therefore never interleaved.
//
// Build option:
//   XENTRY_L2_ARB_ROUND_ROBIN_EN  defined     -> a tie in idle goes to the cache
//                                                that was not served last
//                                 not defined -> fixed priority; dcache wins ties
//
// Address, type, store data and valid of the owner are routed combinationally
// to the L2 port. L2 fulfilment is routed combinationally back to the owner.

package l2_request_arbiter_pkg;
  typedef enum logic {
    LOAD  = 1'b0,
    STORE = 1'b1
  } memory_operation_e;
endpackage

module l2_request_arbiter
  import l2_request_arbiter_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic              clk,
  input  logic              reset_n,

  // instruction cache side
  input  logic              ic_req_valid,
  input  memory_operation_e ic_req_type,
  input  logic [XLEN-1:0]   ic_req_address,
  input  logic [XLEN-1:0]   ic_req_store_word,
  output logic              ic_req_fulfilled,
  output logic [XLEN-1:0]   ic_req_loaded_word,

  // data cache side
  input  logic              dc_req_valid,
  input  memory_operation_e dc_req_type,
  input  logic [XLEN-1:0]   dc_req_address,
  input  logic [XLEN-1:0]   dc_req_store_word,
  output logic              dc_req_fulfilled,
  output logic [XLEN-1:0]   dc_req_loaded_word,

  // L2 side
  output logic              l2_req_valid,
  output memory_operation_e l2_req_type,
  output logic [XLEN-1:0]   l2_req_address,
  output logic [XLEN-1:0]   l2_req_store_word,
  input  logic              l2_req_fulfilled,
  input  logic [XLEN-1:0]   l2_req_loaded_word
);

  localparam int            BW        = $clog2(WORDS_PER_LINE);
  localparam logic [BW-1:0] LAST_BEAT = BW'(WORDS_PER_LINE - 1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_GRANT_IC = 2'd1,
    ST_GRANT_DC = 2'd2
  } state_e;

  state_e        r_state;
  logic [BW-1:0] r_beat_count;
  logic          r_last_served;   // 1 = dcache was the most recent owner

  logic          w_tie_to_dc;     // winner when both caches request in idle
  logic          w_owner_valid;   // valid of whichever cache holds the grant
  logic          w_last_beat;     // current beat closes the line

`ifdef XENTRY_L2_ARB_ROUND_ROBIN_EN
  // Fair tie-break: the cache that was not served last goes first.
  // After reset last_served points at the icache, so the dcache wins first.
  assign w_tie_to_dc = ~r_last_served;
`else
  // Fixed priority: the dcache always wins a tie. last_served is still
  // tracked so both builds carry identical state.
  logic w_unused_last_served;
  assign w_tie_to_dc          = 1'b1;
  assign w_unused_last_served = r_last_served;
`endif

  assign w_last_beat = (r_beat_count == LAST_BEAT);

  // Load data fans out to both caches; each qualifies it with its own fulfilled.
  assign ic_req_loaded_word = l2_req_loaded_word;
  assign dc_req_loaded_word = l2_req_loaded_word;

  // Select the valid of the current owner for abort detection
  always_comb begin
    w_owner_valid = 1'b0;
    case (r_state)
      ST_GRANT_IC: w_owner_valid = ic_req_valid;
      ST_GRANT_DC: w_owner_valid = dc_req_valid;
      default:     w_owner_valid = 1'b0;
    endcase
  end

  // Arbitration FSM: grant, beat counting, release on last beat or abort
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_IDLE;
      r_beat_count  <= '0;
      r_last_served <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // L2 fulfilment is ignored here; only the request valids matter.
          r_beat_count <= '0;
          if (ic_req_valid && dc_req_valid) begin
            r_state <= w_tie_to_dc ? ST_GRANT_DC : ST_GRANT_IC;
          end else if (dc_req_valid) begin
            r_state <= ST_GRANT_DC;
          end else if (ic_req_valid) begin
            r_state <= ST_GRANT_IC;
          end
        end

        ST_GRANT_IC, ST_GRANT_DC: begin
          if (!w_owner_valid) begin
            // Owner withdrew mid-line: drop the grant and forget the partial line.
            r_state       <= ST_IDLE;
            r_beat_count  <= '0;
            r_last_served <= (r_state == ST_GRANT_DC);
          end else if (l2_req_fulfilled) begin
            if (w_last_beat) begin
              r_state       <= ST_IDLE;
              r_beat_count  <= '0;
              r_last_served <= (r_state == ST_GRANT_DC);
            end else begin
              r_beat_count <= r_beat_count + BW'(1);
            end
          end
        end

        default: begin
          r_state <= state_e'(2'bxx);
        end
      endcase
    end
  end

  // Route the owner's request to L2 and L2 fulfilment back to the owner
  always_comb begin
    l2_req_valid      = 1'b0;
    l2_req_type       = LOAD;
    l2_req_address    = '0;
    l2_req_store_word = '0;
    ic_req_fulfilled  = 1'b0;
    dc_req_fulfilled  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        l2_req_valid      = 1'b0;
        l2_req_type       = LOAD;
        l2_req_address    = '0;
        l2_req_store_word = '0;
      end

      ST_GRANT_IC: begin
        l2_req_valid      = ic_req_valid;
        l2_req_type       = ic_req_type;
        l2_req_address    = ic_req_address;
        l2_req_store_word = ic_req_store_word;
        ic_req_fulfilled  = l2_req_fulfilled;
      end

      ST_GRANT_DC: begin
        l2_req_valid      = dc_req_valid;
        l2_req_type       = dc_req_type;
        l2_req_address    = dc_req_address;
        l2_req_store_word = dc_req_store_word;
        dc_req_fulfilled  = l2_req_fulfilled;
      end

      default: begin
        l2_req_valid      = 1'bx;
        l2_req_type       = memory_operation_e'(1'bx);
        l2_req_address    = 'x;
        l2_req_store_word = 'x;
        ic_req_fulfilled  = 1'bx;
        dc_req_fulfilled  = 1'bx;
      end
    endcase
  end

endmodule

// File: tb/tb_l2_request_arbiter.sv
// tb_l2_request_arbiter
// Models both caches as queues of line requests and the L2 as a memory that
// fulfils every cycle. Each test queues lines into the cache models and pushes
// the expected L2 beats (owner, type, address, data, idle gap before the beat)
// into a scoreboard; a monitor pops one entry per cycle with l2_req_valid=1.
// Tie-break expectations follow XENTRY_L2_ARB_ROUND_ROBIN_EN.

module tb_l2_request_arbiter;
  import l2_request_arbiter_pkg::*;

  localparam int XLEN = 32;
  localparam int WPL  = 4;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              ic_req_valid;
  memory_operation_e ic_req_type;
  logic [XLEN-1:0]   ic_req_address;
  logic [XLEN-1:0]   ic_req_store_word;
  logic              ic_req_fulfilled;
  logic [XLEN-1:0]   ic_req_loaded_word;
  logic              dc_req_valid;
  memory_operation_e dc_req_type;
  logic [XLEN-1:0]   dc_req_address;
  logic [XLEN-1:0]   dc_req_store_word;
  logic              dc_req_fulfilled;
  logic [XLEN-1:0]   dc_req_loaded_word;
  logic              l2_req_valid;
  memory_operation_e l2_req_type;
  logic [XLEN-1:0]   l2_req_address;
  logic [XLEN-1:0]   l2_req_store_word;
  logic              l2_req_fulfilled;
  logic [XLEN-1:0]   l2_req_loaded_word;

  always #5 clk = ~clk;

  l2_request_arbiter #(.XLEN(XLEN), .WORDS_PER_LINE(WPL)) dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .ic_req_valid       (ic_req_valid),
    .ic_req_type        (ic_req_type),
    .ic_req_address     (ic_req_address),
    .ic_req_store_word  (ic_req_store_word),
    .ic_req_fulfilled   (ic_req_fulfilled),
    .ic_req_loaded_word (ic_req_loaded_word),
    .dc_req_valid       (dc_req_valid),
    .dc_req_type        (dc_req_type),
    .dc_req_address     (dc_req_address),
    .dc_req_store_word  (dc_req_store_word),
    .dc_req_fulfilled   (dc_req_fulfilled),
    .dc_req_loaded_word (dc_req_loaded_word),
    .l2_req_valid       (l2_req_valid),
    .l2_req_type        (l2_req_type),
    .l2_req_address     (l2_req_address),
    .l2_req_store_word  (l2_req_store_word),
    .l2_req_fulfilled   (l2_req_fulfilled),
    .l2_req_loaded_word (l2_req_loaded_word)
  );

  // owner: 0 = icache, 1 = dcache; gap = idle cycles expected before this beat (-1 = don't care)
  typedef struct {
    int                owner;
    memory_operation_e typ;
    logic [31:0]       addr;
    logic [31:0]       store;
    int                gap;
  } exp_t;

  typedef struct {
    memory_operation_e typ;
    logic [31:0]       base;
    int                nbeats;
  } line_t;

  exp_t  sb[$];
  line_t lines_ic[$];
  line_t lines_dc[$];
  int    bidx_ic, bidx_dc;
  int    hold_ic, hold_dc;

  int    checks   = 0;
  int    failures = 0;
  bit    mon_en   = 1'b0;
  int    idle_run = 0;
  exp_t  mon_e;
  int    mon_owner;

  function automatic logic [31:0] store_of(logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  // Drive both cache request ports from the head of their line queues
  task automatic drive_caches();
    if (lines_ic.size() > 0 && hold_ic == 0) begin
      ic_req_valid      = 1'b1;
      ic_req_type       = lines_ic[0].typ;
      ic_req_address    = lines_ic[0].base + 32'(4 * bidx_ic);
      ic_req_store_word = store_of(ic_req_address);
    end else begin
      ic_req_valid      = 1'b0;
      ic_req_type       = STORE;
      ic_req_address    = 32'hDEAD_BEE0;
      ic_req_store_word = 32'hFFFF_FFFF;
    end
    if (lines_dc.size() > 0 && hold_dc == 0) begin
      dc_req_valid      = 1'b1;
      dc_req_type       = lines_dc[0].typ;
      dc_req_address    = lines_dc[0].base + 32'(4 * bidx_dc);
      dc_req_store_word = store_of(dc_req_address);
    end else begin
      dc_req_valid      = 1'b0;
      dc_req_type       = STORE;
      dc_req_address    = 32'hDEAD_BEE4;
      dc_req_store_word = 32'hFFFF_FFFF;
    end
    l2_req_loaded_word = $urandom();
  endtask

  // One clock of the cache models: a fulfilled beat advances the word; a
  // shortened line (abort) drops valid for one cycle after its last beat.
  task automatic advance();
    bit ic_beat, dc_beat;
    @(negedge clk);
    ic_beat = (ic_req_valid === 1'b1) && (ic_req_fulfilled === 1'b1);
    dc_beat = (dc_req_valid === 1'b1) && (dc_req_fulfilled === 1'b1);
    @(posedge clk);
    #1;
    if (hold_ic > 0) hold_ic--;
    else if (ic_beat) begin
      bidx_ic++;
      if (bidx_ic == lines_ic[0].nbeats) begin
        if (lines_ic[0].nbeats < WPL) hold_ic = 1;
        lines_ic.delete(0);
        bidx_ic = 0;
      end
    end
    if (hold_dc > 0) hold_dc--;
    else if (dc_beat) begin
      bidx_dc++;
      if (bidx_dc == lines_dc[0].nbeats) begin
        if (lines_dc[0].nbeats < WPL) hold_dc = 1;
        lines_dc.delete(0);
        bidx_dc = 0;
      end
    end
    drive_caches();
  endtask

  task automatic queue_line(input int owner, input memory_operation_e typ,
                            input logic [31:0] base, input int nbeats);
    line_t l;
    l.typ    = typ;
    l.base   = base;
    l.nbeats = nbeats;
    if (owner == 1) lines_dc.push_back(l);
    else            lines_ic.push_back(l);
  endtask

  task automatic expect_line(input int owner, input memory_operation_e typ,
                             input logic [31:0] base, input int nbeats, input int first_gap);
    for (int b = 0; b < nbeats; b++) begin
      exp_t e;
      e.owner = owner;
      e.typ   = typ;
      e.addr  = base + 32'(4 * b);
      e.store = store_of(e.addr);
      e.gap   = (b == 0) ? first_gap : 0;
      sb.push_back(e);
    end
  endtask

  // Advance until all queued lines are consumed (bounded), then two idle cycles
  task automatic drain(input int limit, output int used);
    used = 0;
    while ((sb.size() > 0 || lines_ic.size() > 0 || lines_dc.size() > 0) && used < limit) begin
      advance();
      used++;
    end
    repeat (2) advance();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    mon_en  = 1'b0;
    lines_ic.delete();
    lines_dc.delete();
    sb.delete();
    bidx_ic = 0; bidx_dc = 0;
    hold_ic = 0; hold_dc = 0;
    l2_req_fulfilled = 1'b1;
    drive_caches();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  // Scoreboard checker: each cycle with l2_req_valid consumes one expected beat
  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if (ic_req_loaded_word !== l2_req_loaded_word) begin
        failures++;
        $display("FAIL ic_loaded_word got=%h exp=%h", ic_req_loaded_word, l2_req_loaded_word);
      end
      checks++;
      if (dc_req_loaded_word !== l2_req_loaded_word) begin
        failures++;
        $display("FAIL dc_loaded_word got=%h exp=%h", dc_req_loaded_word, l2_req_loaded_word);
      end
      checks++;
      if (ic_req_fulfilled === 1'b1 && dc_req_fulfilled === 1'b1) begin
        failures++;
        $display("FAIL both_fulfilled got ic=1 dc=1 exp at most one");
      end
      if (l2_req_valid === 1'b1) begin
        mon_owner = (dc_req_fulfilled === 1'b1) ? 1 : ((ic_req_fulfilled === 1'b1) ? 0 : -1);
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL unexpected_beat got addr=%h owner=%0d exp no beat", l2_req_address, mon_owner);
        end else begin
          mon_e = sb.pop_front();
          $display("beat owner=%s type=%s addr=%h store=%h gap=%0d",
                   (mon_owner == 1) ? "dc" : "ic", l2_req_type.name(), l2_req_address,
                   l2_req_store_word, idle_run);
          if (mon_owner != mon_e.owner) begin
            failures++;
            $display("FAIL beat_owner got=%0d exp=%0d addr=%h", mon_owner, mon_e.owner, mon_e.addr);
          end
          checks++;
          if (l2_req_type !== mon_e.typ) begin
            failures++;
            $display("FAIL beat_type got=%0d exp=%0d", l2_req_type, mon_e.typ);
          end
          checks++;
          if (l2_req_address !== mon_e.addr) begin
            failures++;
            $display("FAIL beat_addr got=%h exp=%h", l2_req_address, mon_e.addr);
          end
          checks++;
          if (l2_req_store_word !== mon_e.store) begin
            failures++;
            $display("FAIL beat_store got=%h exp=%h", l2_req_store_word, mon_e.store);
          end
          if (mon_e.gap >= 0) begin
            checks++;
            if (idle_run != mon_e.gap) begin
              failures++;
              $display("FAIL beat_gap got=%0d exp=%0d addr=%h", idle_run, mon_e.gap, mon_e.addr);
            end
          end
        end
        idle_run = 0;
      end else begin
        idle_run++;
        if (ic_req_fulfilled === 1'b0 && dc_req_fulfilled === 1'b0) begin
          checks++;
          if (l2_req_type !== LOAD || l2_req_address !== 32'h0 || l2_req_store_word !== 32'h0) begin
            failures++;
            $display("FAIL idle_outputs got type=%0d addr=%h store=%h exp 0/0/0",
                     l2_req_type, l2_req_address, l2_req_store_word);
          end
        end
      end
    end
  end

  task automatic test_reset();
    reset_n           = 1'b0;
    l2_req_fulfilled  = 1'b1;
    ic_req_valid      = 1'b1;  ic_req_type = STORE;
    ic_req_address    = 32'h1234; ic_req_store_word = 32'h5678;
    dc_req_valid      = 1'b1;  dc_req_type = STORE;
    dc_req_address    = 32'h9ABC; dc_req_store_word = 32'hDEF0;
    l2_req_loaded_word = 32'h0;
    @(negedge clk);
    checks++; if (l2_req_valid !== 1'b0) begin failures++; $display("FAIL rst_l2_valid got=%b exp=0", l2_req_valid); end
    checks++; if (l2_req_type !== LOAD) begin failures++; $display("FAIL rst_l2_type got=%0d exp=0", l2_req_type); end
    checks++; if (l2_req_address !== 32'h0) begin failures++; $display("FAIL rst_l2_addr got=%h exp=0", l2_req_address); end
    checks++; if (l2_req_store_word !== 32'h0) begin failures++; $display("FAIL rst_l2_store got=%h exp=0", l2_req_store_word); end
    checks++; if (ic_req_fulfilled !== 1'b0) begin failures++; $display("FAIL rst_ic_fulfilled got=%b exp=0", ic_req_fulfilled); end
    checks++; if (dc_req_fulfilled !== 1'b0) begin failures++; $display("FAIL rst_dc_fulfilled got=%b exp=0", dc_req_fulfilled); end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    #1;
    checks++; if (l2_req_valid !== 1'b0) begin failures++; $display("FAIL post_rst_idle got=%b exp=0", l2_req_valid); end
    @(posedge clk);
    #1;
    // first tie after reset goes to the dcache in both builds
    checks++; if (dc_req_fulfilled !== 1'b1 || l2_req_address !== 32'h9ABC) begin
      failures++;
      $display("FAIL post_rst_first_tie got dc_f=%b addr=%h exp dc_f=1 addr=00009abc", dc_req_fulfilled, l2_req_address);
    end
    $display("reset test done");
  endtask

  task automatic test_dc_line_fill();
    int used;
    do_reset();
    queue_line(1, LOAD, 32'h100, WPL);
    expect_line(1, LOAD, 32'h100, WPL, 1);
    drive_caches();
    idle_run = 0; mon_en = 1'b1;
    drain(200, used);
    mon_en = 1'b0;
    checks++; if (used >= 200) begin failures++; $display("FAIL dc_fill_timeout got=%0d exp<200", used); end
    checks++; if (sb.size() != 0) begin failures++; $display("FAIL dc_fill_leftover got=%0d exp=0", sb.size()); end
    checks++; if (used != WPL + 1) begin failures++; $display("FAIL dc_fill_cycles got=%0d exp=%0d", used, WPL + 1); end
  endtask

  task automatic test_tie();
    int used;
    do_reset();
    queue_line(1, LOAD, 32'h1000, WPL);
    queue_line(1, LOAD, 32'h1010, WPL);
    queue_line(0, LOAD, 32'h2000, WPL);
    expect_line(1, LOAD, 32'h1000, WPL, 1);
`ifdef XENTRY_L2_ARB_ROUND_ROBIN_EN
    expect_line(0, LOAD, 32'h2000, WPL, 1);
    expect_line(1, LOAD, 32'h1010, WPL, 1);
`else
    expect_line(1, LOAD, 32'h1010, WPL, 1);
    expect_line(0, LOAD, 32'h2000, WPL, 1);
`endif
    drive_caches();
    idle_run = 0; mon_en = 1'b1;
    drain(200, used);
    mon_en = 1'b0;
    checks++; if (used >= 200) begin failures++; $display("FAIL tie_timeout got=%0d exp<200", used); end
    checks++; if (sb.size() != 0) begin failures++; $display("FAIL tie_leftover got=%0d exp=0", sb.size()); end
    checks++; if (used != 3 * (WPL + 1)) begin failures++; $display("FAIL tie_cycles got=%0d exp=%0d", used, 3 * (WPL + 1)); end
  endtask

  task automatic test_flush_then_load();
    int used;
    do_reset();
    queue_line(1, STORE, 32'h200, WPL);
    queue_line(1, LOAD,  32'h210, WPL);
    queue_line(0, LOAD,  32'h400, WPL);
    expect_line(1, STORE, 32'h200, WPL, 1);
`ifdef XENTRY_L2_ARB_ROUND_ROBIN_EN
    expect_line(0, LOAD, 32'h400, WPL, 1);
    expect_line(1, LOAD, 32'h210, WPL, 1);
`else
    expect_line(1, LOAD, 32'h210, WPL, 1);
    expect_line(0, LOAD, 32'h400, WPL, 1);
`endif
    drive_caches();
    idle_run = 0; mon_en = 1'b1;
    drain(200, used);
    mon_en = 1'b0;
    checks++; if (used >= 200) begin failures++; $display("FAIL flush_timeout got=%0d exp<200", used); end
    checks++; if (sb.size() != 0) begin failures++; $display("FAIL flush_leftover got=%0d exp=0", sb.size()); end
  endtask

  task automatic test_abort();
    int used;
    do_reset();
    // two beats, valid drops for one cycle, then the full line is re-requested
    queue_line(1, LOAD, 32'h300, 2);
    queue_line(1, LOAD, 32'h300, WPL);
    expect_line(1, LOAD, 32'h300, 2, 1);
    expect_line(1, LOAD, 32'h300, WPL, 2);
    drive_caches();
    idle_run = 0; mon_en = 1'b1;
    drain(200, used);
    mon_en = 1'b0;
    checks++; if (used >= 200) begin failures++; $display("FAIL abort_timeout got=%0d exp<200", used); end
    checks++; if (sb.size() != 0) begin failures++; $display("FAIL abort_leftover got=%0d exp=0", sb.size()); end
    checks++; if (used != 3 + 2 + WPL) begin failures++; $display("FAIL abort_cycles got=%0d exp=%0d", used, 3 + 2 + WPL); end
  endtask

  task automatic test_async_reset();
    int used;
    do_reset();
    queue_line(0, LOAD, 32'h700, WPL);
    drive_caches();
    repeat (3) advance();   // grant cycle, beat 1, beat 2 -> now in beat 3
    #2;
    checks++; if (l2_req_valid !== 1'b1 || ic_req_fulfilled !== 1'b1 || l2_req_address !== 32'h708) begin
      failures++;
      $display("FAIL ares_pre got valid=%b ic_f=%b addr=%h exp 1/1/00000708", l2_req_valid, ic_req_fulfilled, l2_req_address);
    end
    reset_n = 1'b0;
    #1;
    checks++; if (l2_req_valid !== 1'b0) begin failures++; $display("FAIL ares_l2_valid got=%b exp=0", l2_req_valid); end
    checks++; if (ic_req_fulfilled !== 1'b0) begin failures++; $display("FAIL ares_ic_fulfilled got=%b exp=0", ic_req_fulfilled); end
    checks++; if (l2_req_address !== 32'h0) begin failures++; $display("FAIL ares_l2_addr got=%h exp=0", l2_req_address); end
    do_reset();
    queue_line(1, LOAD, 32'h500, WPL);
    queue_line(0, LOAD, 32'h600, WPL);
    expect_line(1, LOAD, 32'h500, WPL, 1);
    expect_line(0, LOAD, 32'h600, WPL, 1);
    drive_caches();
    idle_run = 0; mon_en = 1'b1;
    drain(200, used);
    mon_en = 1'b0;
    checks++; if (used >= 200) begin failures++; $display("FAIL ares_tie_timeout got=%0d exp<200", used); end
    checks++; if (sb.size() != 0) begin failures++; $display("FAIL ares_tie_leftover got=%0d exp=0", sb.size()); end
  endtask

  initial begin
    test_reset();
    test_dc_line_fill();
    test_tie();
    test_flush_then_load();
    test_abort();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
